code_seq_ctrl: RTL and testbench

Sequencer that drives the 3-bit code converter feeding the 7-segment display. It steps the converter's `A` input through 0–7 at a programmable rate, either free-running or one step per request. It owns the converter's `USE_GRAY` select and applies mode changes only at safe points, so a sweep never mixes encodings. It sits between the board's button/switch conditioning logic and the converter.

---
 rtl/code_seq_ctrl.sv | 116 +++++++++++
 tb/tb_code_seq_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/code_seq_ctrl.sv
// code_seq_ctrl
//   Steps the 3-bit code converter input A through 0..7, either free-running
//   (one advance every TICK_DIV cycles) or one advance per step request.
//   Owns the converter's USE_GRAY select. While sweeping, a mode change is
//   held back until the sweep wraps, so one pass never mixes encodings.
//
// Parameters
//   TICK_DIV  clock cycles per automatic advance (2 .. 2^24)
//   CNT_W     tick counter width, 2^CNT_W >= TICK_DIV
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     pulse: enter free-running sweep
//   stop      pulse: halt sweep, hold current code (highest priority)
//   step      pulse: single advance while idle
//   dir       0 = up, 1 = down, sampled at each advance
//   gray_req  requested encoding mode (level)
//   A         code index to converter (registered)
//   USE_GRAY  mode select to converter (registered)
//   busy      high while sweeping
//   wrap      one-cycle pulse coincident with the wrapped A value
module code_seq_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       dir,
    input  logic       gray_req,
    output logic [2:0] A,
    output logic       USE_GRAY,
    output logic       busy,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;

    logic       tick_hit;
    logic [2:0] a_next;
    logic       a_wraps;

    always_comb begin
        tick_hit = (tick_cnt == TICK_LAST);
        a_next   = dir ? (A - 3'd1) : (A + 3'd1);
        a_wraps  = dir ? (A == 3'd0) : (A == 3'd7);
    end

    // The request level itself serves as the pending mode during RUN: it is
    // only transferred to USE_GRAY on a wrapping advance, or once the block
    // is back in IDLE (which covers a stop that lands before the wrap).
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            A        <= 3'd0;
            USE_GRAY <= 1'b0;
            busy     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    USE_GRAY <= gray_req;
                    if (stop) begin
                        state <= IDLE;
                    end else if (start) begin
                        state    <= RUN;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                    end else if (step) begin
                        state <= STEP;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // no advance on the stop edge, even if the tick fires
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tick_cnt <= '0;
                    end else if (tick_hit) begin
                        tick_cnt <= '0;
                        A        <= a_next;
                        wrap     <= a_wraps;
                        if (a_wraps) USE_GRAY <= gray_req;
                    end else begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end
                STEP: begin
                    A        <= a_next;
                    wrap     <= a_wraps;
                    USE_GRAY <= gray_req;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_seq_ctrl.sv
// Bench for code_seq_ctrl: directed vector table, hand-written corner
// sequences, then randomized pulses checked against a cycle-level model.
module tb_code_seq_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst, start, stop, step, dir, gray_req;
    logic [2:0] A;
    logic       USE_GRAY, busy, wrap;

    always #5 clk = ~clk;

    code_seq_ctrl #(.TICK_DIV(TD), .CNT_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
        .dir(dir), .gray_req(gray_req),
        .A(A), .USE_GRAY(USE_GRAY), .busy(busy), .wrap(wrap)
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference model: mode 0 idle, 1 sweeping, 2 single step pending
    int m_mode = 0;
    int m_age  = 0;   // cycles spent sweeping since start
    int m_code = 0;
    bit m_gray = 0;
    bit m_wrap = 0;
    bit m_busy = 0;

    typedef struct {
        bit       r, sa, so, se, d, g;
        logic [2:0] ea;
        bit       eg, eb, ew;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit r, input bit sa, input bit so, input bit se,
                          input bit d, input bit g);
        rst = r; start = sa; stop = so; step = se; dir = d; gray_req = g;
    endtask

    task automatic model_advance();
        m_wrap = dir ? (m_code == 0) : (m_code == 7);
        m_code = (m_code + (dir ? 7 : 1)) % 8;
    endtask

    task automatic model_edge();
        if (rst) begin
            m_mode = 0; m_age = 0; m_code = 0; m_gray = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            case (m_mode)
                0: begin
                    m_gray = gray_req;
                    if (!stop && start) begin
                        m_mode = 1; m_age = 0;
                    end else if (!stop && step) begin
                        m_mode = 2;
                    end
                end
                1: begin
                    if (stop) m_mode = 0;
                    else begin
                        m_age++;
                        if (m_age % TD == 0) begin
                            model_advance();
                            if (m_wrap) m_gray = gray_req;
                        end
                    end
                end
                default: begin
                    model_advance();
                    m_gray = gray_req;
                    m_mode = 0;
                end
            endcase
        end
        m_busy = (m_mode == 1);
    endtask

    // one clock: model follows the same sampled inputs, outputs compared 1ns later
    task automatic cyc();
        logic [5:0] act, exp;
        @(posedge clk);
        model_edge();
        #1;
        act = {A, USE_GRAY, busy, wrap};
        exp = {3'(m_code), m_gray, m_busy, m_wrap};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL model: got A=%0d g=%0b b=%0b w=%0b expected A=%0d g=%0b b=%0b w=%0b at %0t",
                     act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0], $time);
        end
    endtask

    initial begin
        bit seen;
        set_in(1, 0, 0, 0, 0, 0);

        //            r  sa so se d  g   A     g  b  w
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 1, 0, 3'd0, 0, 0, 0};  // step down from 0
        tbl[4]  = '{0, 0, 0, 0, 1, 0, 3'd7, 0, 0, 1};  // wrapped to 7
        tbl[5]  = '{0, 0, 0, 0, 1, 0, 3'd7, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 3'd7, 0, 1, 0};  // start
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 3'd7, 0, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 3'd7, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 3'd7, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1};  // start + TD, wrap up
        tbl[11] = '{0, 0, 1, 0, 0, 0, 3'd0, 0, 0, 0};  // stop
        tbl[12] = '{0, 1, 1, 0, 0, 0, 3'd0, 0, 0, 0};  // stop beats start
        tbl[13] = '{0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 0};  // idle follows gray_req
        tbl[14] = '{0, 0, 0, 1, 0, 1, 3'd0, 1, 0, 0};  // step up
        tbl[15] = '{0, 0, 0, 0, 0, 1, 3'd1, 1, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0};

        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].r, tbl[i].sa, tbl[i].so, tbl[i].se, tbl[i].d, tbl[i].g);
            cyc();
            chk($sformatf("table[%0d]", i), {A, USE_GRAY, busy, wrap},
                {tbl[i].ea, tbl[i].eg, tbl[i].eb, tbl[i].ew});
        end

        // reset then 10 idle cycles
        set_in(1, 0, 0, 0, 0, 0);
        cyc();
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_state", {A, USE_GRAY, busy, wrap}, 0);
        end

        // full up sweep: A=k/4 after edge k, wrap only at edge 32
        set_in(0, 1, 0, 0, 0, 0);
        cyc();
        chk("sweep_busy", busy, 1);
        set_in(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 33; k++) begin
            cyc();
            chk("sweep_A", A, (k / 4) % 8);
            chk("sweep_wrap", wrap, (k == 32) ? 1 : 0);
        end

        // gray request mid-sweep at A=3 is deferred to the wrap
        for (int i = 0; i < 60 && m_code != 3; i++) cyc();
        chk("reach_A3", A, 3);
        set_in(0, 0, 0, 0, 0, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (m_wrap) begin
                chk("gray_at_wrap", USE_GRAY, 1);
                chk("gray_wrap_A", A, 0);
                seen = 1;
                break;
            end
            chk("gray_deferred", USE_GRAY, 0);
        end
        chk("gray_wrap_seen", seen, 1);

        // start+stop on the edge the tick would fire: no advance
        for (int i = 0; i < TD - 1; i++) cyc();
        set_in(0, 1, 1, 0, 0, 1);
        cyc();
        chk("ss_busy", busy, 0);
        chk("ss_A", A, 0);
        chk("ss_wrap", wrap, 0);
        set_in(0, 0, 0, 0, 0, 1);
        cyc();
        chk("ss_hold_A", A, 0);

        // reset mid-sweep at A=5 with a pending mode change
        set_in(0, 1, 0, 0, 0, 1);
        cyc();
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 60 && m_code != 5; i++) cyc();
        chk("reach_A5", A, 5);
        chk("pending_held", USE_GRAY, 1);
        set_in(1, 0, 0, 0, 0, 0);
        cyc();
        chk("rst_run", {A, USE_GRAY, busy, wrap}, 0);
        set_in(0, 0, 0, 0, 0, 0);
        cyc();
        chk("rst_after", {A, USE_GRAY, busy, wrap}, 0);

        // randomized pulses against the model
        begin
            bit d, g;
            d = 0; g = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 15) == 0) d = ~d;
                if ($urandom_range(0, 24) == 0) g = ~g;
                set_in($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0, d, g);
                cyc();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
